onehot_strobe_decoder: RTL and testbench
========================================

// Module: onehot_strobe_decoder
// PURPOSE
//  Reverse path of the 8-line priority encoder. Accepts a stream of encoded line indices
//  through a valid/ready handshake and buffers them in a small FIFO. Replays each index as
//  a one-hot strobe on OUT_W lines, held for exactly HOLD cycles. Entries are replayed
//  back-to-back with no gap cycles. Sits between the encoder side and the per-line
//  consumers that need a timed one-hot select.
// PARAMETERS
//  IDX_W       3   width of encoded index
//  OUT_W       8   number of one-hot lines; must equal 2**IDX_W
//  HOLD        2   cycles each strobe is held; legal range 1..255
//  FIFO_DEPTH  4   index FIFO entries; power of two, >=2
// PORTS
//  clk         in   1                      rising-edge clock
//  rst_n       in   1                      asynchronous active-low reset
//  in_valid    in   1                      in_idx/in_none valid this cycle
//  in_ready    out  1                      FIFO can accept; comb = rst_n && (fifo_count < FIFO_DEPTH)
//  in_idx      in   IDX_W                  encoded line index
//  in_none     in   1                      1 = no line active (encoder all-zero input); in_idx ignored
//  out_strobe  out  OUT_W                  one-hot strobe (all-zero for a none entry or when idle)
//  out_valid   out  1                      1 while a FIFO entry is being driven
//  busy        out  1                      (state==DRIVE) || (fifo_count!=0)
//  fifo_count  out  $clog2(FIFO_DEPTH)+1   occupancy, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, rst_n low):
//   - FIFO empty, fifo_count=0, state=IDLE, hold counter=0.
//   - out_strobe=0, out_valid=0, busy=0, in_ready=0.
//   - Entries in flight are discarded. The first post-reset edge acts as IDLE.
//  Push:
//   - Occurs on a rising edge with in_valid && in_ready; stores {in_none, in_idx}.
//   - in_ready depends only on the registered count. A pop in the same cycle does NOT
//     open a slot when full (no bypass). in_valid while in_ready=0 is ignored; no overflow.
//  FSM (two states):
//   - IDLE: if fifo_count!=0 at the edge, pop head, load out_strobe = none ? 0 : (1<<idx),
//     out_valid=1, hold_cnt=HOLD-1, go DRIVE. Otherwise out_strobe=0, out_valid=0.
//   - DRIVE: if hold_cnt!=0, decrement it and hold outputs.
//     If hold_cnt==0 and FIFO non-empty, pop and reload as in IDLE (back-to-back, no bubble).
//     If hold_cnt==0 and FIFO empty, clear out_strobe and out_valid, go IDLE.
//  Latency: push at edge k into an empty FIFO with state IDLE -> out_valid=1 after edge
//   k+1. Each entry drives exactly HOLD cycles. The FIFO never bypasses to the output.
//  Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Ordering: strict FIFO order. Repeated identical indices still produce separate
//   HOLD-cycle windows, distinguishable only by out_valid timing.
//  A none entry occupies HOLD cycles with out_valid=1 and out_strobe=0.
//  out_strobe has at most one bit set in every cycle.
//  All outputs except in_ready are registered.
// TESTING
//  1 reset: rst_n=0 mid-DRIVE with 3 entries queued -> out_strobe=0, out_valid=0,
//    fifo_count=0, in_ready=0 immediately, before any clock edge.
//  2 single entry: HOLD=2, push idx=5 at edge k -> out_strobe=8'b0010_0000 and
//    out_valid=1 after edges k+1 and k+2; both 0 after edge k+3; busy=0 after edge k+3.
//  3 back-to-back: push 7,0,3 on consecutive edges -> strobes 0x80,0x01,0x08, each held
//    2 cycles, no gap cycle between them.
//  4 full: with out_valid held, push 5 entries with in_valid=1 continuously ->
//    in_ready=0 at count=4, 5th entry is accepted only after a pop, no entry is lost or
//    duplicated, order is preserved.
//  5 none entry: push in_none=1 (in_idx=3'b110) -> out_valid=1, out_strobe=0 for HOLD
//    cycles, then the next entry proceeds normally.
//  6 random: 200 random pushes with random in_valid gaps, HOLD=1 and HOLD=3 ->
//    scoreboard matches order, one-hot property holds every cycle, count never exceeds 4.

Source files
------------

// File: rtl/onehot_strobe_decoder.sv
// rtl/onehot_strobe_decoder.sv - FIFO-buffered replay of encoded line indices as timed one-hot strobes
// The index queue is its own module so the replay FSM only sees push/pop and a registered count.

module onehot_strobe_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head = mem[rd_ptr];

endmodule

module onehot_strobe_decoder #(
  parameter  int IDX_W      = 3,
  parameter  int OUT_W      = 8,
  parameter  int HOLD       = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_none,
  output logic [OUT_W-1:0] out_strobe,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [CNT_W-1:0] FULL      = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       hold_cnt;
  logic [7:0]       hold_nxt;
  logic [OUT_W-1:0] strobe_nxt;
  logic             valid_nxt;
  logic             push;
  logic             pop;
  logic [IDX_W:0]   head;
  logic             fifo_empty;
  logic [CNT_W-1:0] count_nxt;

  // Slot availability looks only at the registered count: a same-cycle pop never frees a slot
  assign in_ready   = rst_n && (fifo_count < FULL);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_count == '0);
  assign count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);

  onehot_strobe_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in_none, in_idx}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  function automatic logic [OUT_W-1:0] decode(input logic [IDX_W:0] entry);
    decode = entry[IDX_W] ? '0 : (OUT_W'(1) << entry[IDX_W-1:0]);
  endfunction

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    strobe_nxt = out_strobe;
    valid_nxt  = out_valid;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        strobe_nxt = '0;
        valid_nxt  = 1'b0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          strobe_nxt = decode(head);
          valid_nxt  = 1'b1;
          hold_nxt   = HOLD_LOAD;
          state_nxt  = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_cnt != 8'd0) begin
          hold_nxt = hold_cnt - 8'd1;
        end else if (!fifo_empty) begin
          // reload straight from the queue so consecutive windows have no bubble
          pop        = 1'b1;
          strobe_nxt = decode(head);
          valid_nxt  = 1'b1;
          hold_nxt   = HOLD_LOAD;
        end else begin
          strobe_nxt = '0;
          valid_nxt  = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= 8'd0;
      out_strobe <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      out_strobe <= strobe_nxt;
      out_valid  <= valid_nxt;
      busy       <= (state_nxt == DRIVE) || (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// tb/tb_onehot_strobe_decoder.sv - scoreboard bench for onehot_strobe_decoder at HOLD=2, 1 and 3
// Instance 0 (HOLD=2) takes the directed steps; instances 1 and 2 take random traffic.

module tb_onehot_strobe_decoder;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid   [N];
  logic       in_ready   [N];
  logic [2:0] in_idx     [N];
  logic       in_none    [N];
  logic [7:0] out_strobe [N];
  logic       out_valid  [N];
  logic       busy       [N];
  logic [2:0] fifo_count [N];

  int checks = 0;
  int errors = 0;

  logic [3:0] q0 [$];
  logic [3:0] q1 [$];
  logic [3:0] q2 [$];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < N; g++) begin : g_dut
    localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    onehot_strobe_decoder #(
      .IDX_W      (3),
      .OUT_W      (8),
      .HOLD       (H),
      .FIFO_DEPTH (4)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_idx     (in_idx[g]),
      .in_none    (in_none[g]),
      .out_strobe (out_strobe[g]),
      .out_valid  (out_valid[g]),
      .busy       (busy[g]),
      .fifo_count (fifo_count[g])
    );
  end

  function automatic int hold_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int sb_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic sb_push(input int i, input logic [3:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int i, output logic [3:0] v);
    case (i)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic sb_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds in_valid until accepted, returns at the negedge after acceptance
  task automatic send(input int i, input logic none, input logic [2:0] idx, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    in_valid[i] = 1'b1;
    in_none[i]  = none;
    in_idx[i]   = idx;
    for (int t = 0; t < 64; t++) begin
      acc = in_ready[i];
      @(posedge clk);
      if (acc) begin
        sb_push(i, {none, idx});
        break;
      end
      waits++;
      @(negedge clk);
    end
    if (acc) @(negedge clk);
    check("send_accepted", acc, 1);
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 3000; t++) begin
      if (!busy[i]) break;
      @(negedge clk);
    end
    check("drain_busy", busy[i], 0);
    check("drain_sb_empty", sb_size(i), 0);
  endtask

  int         run_len [N];
  logic       prev_v  [N];
  logic [7:0] cur_exp [N];

  // Window tracker: a new HOLD-long window starts when out_valid rises or the previous one has run out
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        run_len[i] = 0;
        prev_v[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        logic [3:0] e;
        check("onehot", $onehot0(out_strobe[i]), 1);
        check("count_max", fifo_count[i] <= 3'd4, 1);
        if (out_valid[i]) begin
          if (!prev_v[i] || run_len[i] == hold_of(i)) begin
            check("sb_nonempty", sb_size(i) != 0, 1);
            if (sb_size(i) != 0) begin
              sb_pop(i, e);
              cur_exp[i] = e[3] ? 8'h00 : (8'h01 << e[2:0]);
            end
            run_len[i] = 1;
          end else begin
            run_len[i] = run_len[i] + 1;
          end
          check("strobe", out_strobe[i], cur_exp[i]);
        end else begin
          if (prev_v[i]) check("window_len", run_len[i], hold_of(i));
          check("idle_strobe", out_strobe[i], 0);
          run_len[i] = 0;
        end
        prev_v[i] = out_valid[i];
      end
    end
  end

  initial begin
    int         w;
    int         gap;
    logic [7:0] exp3 [4];

    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      in_idx[i]   = 3'd0;
      in_none[i]  = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("reset_strobe", out_strobe[0], 0);
    check("reset_valid", out_valid[0], 0);
    check("reset_count", fifo_count[0], 0);
    check("reset_in_ready", in_ready[0], 0);
    check("reset_busy", busy[0], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", in_ready[0], 1);

    // single entry latency and hold
    send(0, 1'b0, 3'd5, w);
    check("t2_no_bypass", out_valid[0], 0);
    check("t2_count", fifo_count[0], 1);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("t2_k1_strobe", out_strobe[0], 8'h20);
    check("t2_k1_valid", out_valid[0], 1);
    @(negedge clk);
    check("t2_k2_strobe", out_strobe[0], 8'h20);
    check("t2_k2_valid", out_valid[0], 1);
    @(negedge clk);
    check("t2_k3_strobe", out_strobe[0], 8'h00);
    check("t2_k3_valid", out_valid[0], 0);
    check("t2_k3_busy", busy[0], 0);

    // back-to-back windows with no gap
    send(0, 1'b0, 3'd7, w);
    send(0, 1'b0, 3'd0, w);
    check("t3_k1", out_strobe[0], 8'h80);
    send(0, 1'b0, 3'd3, w);
    check("t3_k2", out_strobe[0], 8'h80);
    in_valid[0] = 1'b0;
    exp3 = '{8'h01, 8'h01, 8'h08, 8'h08};
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t3_seq", out_strobe[0], exp3[j]);
      check("t3_valid", out_valid[0], 1);
    end
    @(negedge clk);
    check("t3_end_valid", out_valid[0], 0);

    // fill the queue: continuous pushes outrun the HOLD=2 drain
    for (int j = 0; j < 7; j++) send(0, 1'b0, 3'(j), w);
    check("t4_full_count", fifo_count[0], 4);
    check("t4_full_ready", in_ready[0], 0);
    send(0, 1'b0, 3'd7, w);
    check("t4_wait_for_pop", w, 1);
    in_valid[0] = 1'b0;
    drain(0);

    // none entry followed by a normal entry
    send(0, 1'b1, 3'b110, w);
    send(0, 1'b0, 3'd2, w);
    check("t5_k1_valid", out_valid[0], 1);
    check("t5_k1_strobe", out_strobe[0], 8'h00);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_k2_valid", out_valid[0], 1);
    check("t5_k2_strobe", out_strobe[0], 8'h00);
    @(negedge clk);
    check("t5_k3_valid", out_valid[0], 1);
    check("t5_k3_strobe", out_strobe[0], 8'h04);
    drain(0);

    // asynchronous reset mid-DRIVE with three entries queued
    for (int j = 0; j < 6; j++) send(0, 1'b0, 3'(j + 1), w);
    check("t1_pre_count", fifo_count[0], 3);
    check("t1_pre_valid", out_valid[0], 1);
    in_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    sb_clear(0);
    #1;
    check("t1_strobe", out_strobe[0], 0);
    check("t1_valid", out_valid[0], 0);
    check("t1_count", fifo_count[0], 0);
    check("t1_in_ready", in_ready[0], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("t1_after_valid", out_valid[0], 0);
    check("t1_after_count", fifo_count[0], 0);
    check("t1_after_ready", in_ready[0], 1);
    check("t1_after_busy", busy[0], 0);

    // random traffic on HOLD=1 and HOLD=3
    for (int i = 1; i < N; i++) begin
      for (int n = 0; n < 200; n++) begin
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          in_valid[i] = 1'b0;
          repeat (gap) @(negedge clk);
        end
        send(i, $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), w);
      end
      in_valid[i] = 1'b0;
      drain(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
